// File: rtl/dual_port_ram2.sv
// Asymmetric single-clock RAM: byte-wide write port A, registered 32-bit read port B.
// After reset a sequencer writes INIT_VALUE to every word before traffic is accepted.
module dual_port_ram2 #(
  parameter int unsigned ADDRB_W    = 9,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wea,
  input  logic [ADDRB_W+1:0] addra,
  input  logic [7:0]         dia,
  input  logic [ADDRB_W-1:0] addrb,
  output logic [31:0]        dob,
  output logic               ready
);

  localparam int unsigned        DEPTH    = 1 << ADDRB_W;
  localparam logic [ADDRB_W-1:0] PTR_LAST = '1;
  localparam logic [ADDRB_W-1:0] PTR_ONE  = {{(ADDRB_W-1){1'b0}}, 1'b1};

  typedef enum logic {CLEAR, RUN} state_e;

  state_e             state_q, state_d;
  logic [ADDRB_W-1:0] ptr_q, ptr_d;
  logic               clear_we;
  logic               user_we;
  logic [ADDRB_W-1:0] waddr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + PTR_ONE;
      if (ptr_q == PTR_LAST) state_d = RUN;
    end
  end

  assign ready    = (state_q == RUN);
  assign clear_we = (state_q == CLEAR) && !rst;
  assign user_we  = ready && wea && !rst;
  assign waddr    = clear_we ? ptr_q : addra[ADDRB_W+1:2];

  // One byte-wide bank per lane; the clear drives all four lanes through the write port.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    logic       lane_we;
    logic [7:0] lane_wd;

    assign lane_we = clear_we || (user_we && (addra[1:0] == 2'(k)));
    assign lane_wd = clear_we ? INIT_VALUE[8*k +: 8] : dia;

    // NOTE: the array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
      if (lane_we) mem[waddr] <= lane_wd;
    end

    always_ff @(posedge clk) begin
      if (rst)        rd_q <= '0;
      else if (ready) rd_q <= mem[addrb];
    end

    assign dob[8*k +: 8] = rd_q;
  end

endmodule

// File: tb/tb_dual_port_ram2.sv
// Self-checking bench for dual_port_ram2: directed scenarios plus random traffic
// compared against a word-array reference model updated with byte arithmetic.
module tb_dual_port_ram2;

  localparam int unsigned ADDRB_W = 9;
  localparam int unsigned DEPTH   = 1 << ADDRB_W;
  localparam logic [31:0] INIT    = 32'h0000_0000;

  logic               clk;
  logic               rst;
  logic               wea;
  logic [ADDRB_W+1:0] addra;
  logic [7:0]         dia;
  logic [ADDRB_W-1:0] addrb;
  logic [31:0]        dob;
  logic               ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];

  dual_port_ram2 #(.ADDRB_W(ADDRB_W), .INIT_VALUE(INIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .wea   (wea),
    .addra (addra),
    .dia   (dia),
    .addrb (addrb),
    .dob   (dob),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = INIT;
  endtask

  task automatic model_write(input logic [ADDRB_W+1:0] a, input logic [7:0] d);
    int w;
    int lane;
    w    = int'(a) / 4;
    lane = int'(a) % 4;
    mem_m[w][8*lane +: 8] = d;
  endtask

  // Release reset and count edges until ready; optionally poke a write mid-clear.
  task automatic wait_clear(input string tag, input bit poke);
    int cnt;
    cnt = 0;
    rst = 1'b0;
    while (!ready && cnt < 1000) begin
      wea   = poke && (cnt == 5 || cnt == 6);
      addra = '0;
      dia   = 8'hFF;
      tick();
      cnt++;
      if (cnt == 256) check({tag, "_dob_mid_clear"}, dob, 32'h0);
    end
    wea = 1'b0;
    check({tag, "_clear_cycles"}, 32'(cnt), 32'd512);
  endtask

  task automatic write_byte(input logic [ADDRB_W+1:0] a, input logic [7:0] d);
    wea   = 1'b1;
    addra = a;
    dia   = d;
    tick();
    wea   = 1'b0;
    model_write(a, d);
  endtask

  task automatic read_word(input string tag, input logic [ADDRB_W-1:0] b, input logic [31:0] exp);
    addrb = b;
    tick();
    check(tag, dob, exp);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      addrb = ADDRB_W'(i);
      tick();
      check(tag, dob, mem_m[i]);
    end
  endtask

  initial begin
    rst   = 1'b1;
    wea   = 1'b0;
    addra = '0;
    dia   = '0;
    addrb = '0;
    model_clear();

    // Reset state
    tick(); tick(); tick();
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_dob", dob, 32'h0);

    // Clear timing, with a write attempt while not ready
    wait_clear("clear1", 1'b1);
    check("ready_after_clear", 32'(ready), 32'h1);
    read_word("poke_ignored", '0, 32'h0000_0000);
    read_all("clear1_all");

    // Byte packing
    write_byte(0, 8'h21); write_byte(1, 8'h43); write_byte(2, 8'h65); write_byte(3, 8'h87);
    write_byte(4, 8'h21); write_byte(5, 8'h43); write_byte(6, 8'h65); write_byte(7, 8'h87);
    read_word("pack_w0", 0, 32'h8765_4321);
    read_word("pack_w1", 1, 32'h8765_4321);
    read_word("pack_w10", 10, 32'h0000_0000);

    // Partial write
    write_byte(6, 8'hAA);
    read_word("partial_w1", 1, 32'h87AA_4321);

    // Read-first collision
    addrb = 0;
    tick();
    wea = 1'b1; addra = 0; dia = 8'h55;
    tick();
    check("collision_old", dob, 32'h8765_4321);
    wea = 1'b0;
    model_write(0, 8'h55);
    tick();
    check("collision_new", dob, 32'h8765_4355);

    // Random traffic concentrated on a few words to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [31:0] exp;
      wea   = 1'($urandom_range(0, 1));
      addra = (ADDRB_W+2)'($urandom_range(0, 63));
      dia   = 8'($urandom);
      addrb = ADDRB_W'($urandom_range(0, 15));
      exp   = mem_m[addrb];
      tick();
      check("random_read", dob, exp);
      if (wea) model_write(addra, dia);
    end
    wea = 1'b0;
    for (int i = 0; i < 16; i++) read_word("random_final", ADDRB_W'(i), mem_m[i]);

    // Fill more words, then reset mid-operation
    for (int i = 0; i < 40; i++) write_byte((ADDRB_W+2)'(1000 + i), 8'(i + 1));
    read_word("prefill_w250", 250, mem_m[250]);
    rst = 1'b1;
    tick();
    check("midrst_ready", 32'(ready), 32'h0);
    check("midrst_dob", dob, 32'h0);
    tick(); tick();
    model_clear();
    wait_clear("clear2", 1'b0);
    read_all("clear2_all");

    // Normal write after re-clear, top address wrap lane
    write_byte(9, 8'h5A);
    read_word("post_w2", 2, 32'h0000_5A00);
    write_byte(11'h7FF, 8'hC3);
    read_word("top_word", 9'h1FF, 32'hC300_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram2.md
Name: dual_port_ram2

Overview:
Single-clock, asymmetric dual-port RAM.
- Port A is a byte-wide write port.
- Port B is a 32-bit word-wide read port.
- It sits between a byte-oriented producer (e.g. a pixel/frame loader) and a consumer that fetches packed 32-bit words.
- After reset, an internal sequencer clears the whole array before the RAM accepts traffic.

Parameters:
- ADDRB_W, 9: word address width. Depth is 2^ADDRB_W 32-bit words; port A address width is ADDRB_W+2.
- INIT_VALUE, 32'h0000_0000: word value written to every location during the post-reset clear.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wea  input  1  port A write enable.
- addra  input  11 (ADDRB_W+2)  port A byte address.
- dia  input  8  port A write data.
- addrb  input  9 (ADDRB_W)  port B word address.
- dob  output  32  port B registered read data.
- ready  output  1  high once the post-reset clear has completed.

Behaviour:
- Byte mapping:
  - addra[ADDRB_W+1:2] selects the word; addra[1:0] selects byte lane k.
  - A write to lane k updates word bits [8k+7:8k] only; other lanes are unchanged (little-endian).
  - Example: bytes 21,43,65,87 written to addra 0..3 give word 0 = 32'h87654321.
- Write:
  - When wea=1 and ready=1 at a rising edge, the byte is committed on that edge.
  - wea is ignored while ready=0.
- Read:
  - dob registers mem[addrb] every cycle when ready=1. Latency is 1 clock from addrb to dob.
  - A new addrb presented before edge n appears on dob after edge n.
- Read/write collision (same word, same edge): read-first. dob returns the pre-write word, and the new byte is visible on the next read.
- Reset:
  - While rst=1: dob=0, ready=0, and the clear pointer is set to 0.
  - Reset mid-clear or mid-operation restarts the clear from word 0.
- Clear FSM states:
  - CLEAR:
    - Entered on the cycle after rst deasserts.
    - Writes INIT_VALUE to word[ptr] and increments ptr once per clock.
    - When ptr = 2^ADDRB_W-1, the write is done and the FSM moves to RUN.
    - Takes exactly 2^ADDRB_W cycles (512 by default).
    - dob holds 0 throughout.
  - RUN:
    - ready=1; normal operation.
    - Stays here until rst.
- Address wrap: addresses are taken modulo the array size; no out-of-range detection.
- Memory must map to inferred block RAM:
  - one 32-bit array with byte-lane write masking, or 4 byte-wide banks;
  - synchronous read;
  - the clear is performed through the write port, not a reset of the array.

Test Plan:
- Clear check: assert rst 3 cycles, release, count cycles. ready rises exactly 512 cycles after deassert; reading all 512 words returns 32'h00000000.
- Byte packing: write 21,43,65,87 to addra 0..3, then 21,43,65,87 to addra 4..7. Read addrb=0 gives 32'h87654321 one cycle later; addrb=1 gives 32'h87654321; addrb=10 gives 32'h00000000.
- Partial write: after the above, write 8'hAA to addra 6. Reading addrb=1 gives 32'h87AA4321.
- Collision: with addrb=0 held, write 8'h55 to addra 0. dob on that edge shows 32'h87654321; the next cycle shows 32'h87654355.
- Writes during clear: pulse wea with addra=0, dia=FF while ready=0. After ready, word 0 reads 32'h00000000.
- Reset mid-operation: fill words, assert rst mid-run. dob=0 and ready=0 immediately; after a full 512-cycle re-clear, all words read 0; the final write then works normally.
